// File: rtl/muldiv_seq_pkg.sv
// rtl/muldiv_seq_pkg.sv - shared op/state types and alufunc decode for the muldiv sequencer
package muldiv_seq_pkg;

  typedef enum logic [2:0] {
    MD_MUL  = 3'd0,
    MD_DIV  = 3'd1,
    MD_DIVU = 3'd2,
    MD_REM  = 3'd3,
    MD_REMU = 3'd4
  } md_op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MUL   = 3'd1,
    ST_DIV   = 3'd2,
    ST_FIXUP = 3'd3,
    ST_DONE  = 3'd4
  } md_state_t;

  // Reserved encodings fall back to multiply.
  function automatic md_op_t md_op_from_alufunc(input logic [2:0] alufunc);
    case (alufunc)
      3'd1:    return MD_DIV;
      3'd2:    return MD_DIVU;
      3'd3:    return MD_REM;
      3'd4:    return MD_REMU;
      default: return MD_MUL;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_divstep.sv
// rtl/muldiv_divstep.sv - one combinational restoring divide step
// Shifts the next dividend bit into the remainder and keeps the trial subtract if it fits.
module muldiv_divstep #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] div_in,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff_lo;
  logic            ge;

  assign shifted = {rem_in, quo_in[XLEN-1]};
  assign ge      = (shifted >= {1'b0, div_in});
  // When the subtract fits, the difference is below div_in, so the low bits are exact.
  assign diff_lo = shifted[XLEN-1:0] - div_in;
  assign rem_out = ge ? diff_lo : shifted[XLEN-1:0];
  assign quo_out = {quo_in[XLEN-2:0], ge};

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle MUL/DIV/REM sequencer with flush and result handoff
// Optional MULDIV_FAST_MUL_EN: single-cycle multiply instead of the iterative shift-add.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic            in_word,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
    return {{(XLEN-32){x[31]}}, x[31:0]};
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] x);
    return {{(XLEN-32){1'b0}}, x[31:0]};
  endfunction

  function automatic logic [XLEN-1:0] fin(input logic [XLEN-1:0] x, input logic w);
    return w ? sext32(x) : x;
  endfunction

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  acc_q, acc_d;
  logic [XLEN-1:0]  opa_q, opa_d;
  logic [XLEN-1:0]  opb_q, opb_d;
  logic             word_q, word_d;
  logic             is_rem_q, is_rem_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic [XLEN-1:0]  out_result_q, out_result_d;

  md_op_t          op;
  logic            is_signed, is_mul, is_rem;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_neg;
  logic            sa, sb, div_zero, ovf;
  logic [XLEN-1:0] mul_acc_nx, ds_rem, ds_quo, q_fix, r_fix;

  assign op        = md_op_from_alufunc(in_op);
  assign is_signed = (op == MD_DIV) || (op == MD_REM);
  assign is_mul    = (op == MD_MUL);
  assign is_rem    = (op == MD_REM) || (op == MD_REMU);

  assign a_ext   = in_word ? (is_signed ? sext32(in_a) : zext32(in_a)) : in_a;
  assign b_ext   = in_word ? (is_signed ? sext32(in_b) : zext32(in_b)) : in_b;
  assign min_neg = in_word ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};

  assign sa       = is_signed & a_ext[XLEN-1];
  assign sb       = is_signed & b_ext[XLEN-1];
  assign a_mag    = sa ? -a_ext : a_ext;
  assign b_mag    = sb ? -b_ext : b_ext;
  assign div_zero = (b_ext == '0);
  assign ovf      = is_signed && (a_ext == min_neg) && (b_ext == '1);

  assign mul_acc_nx = acc_q + (opb_q[0] ? opa_q : '0);
  assign q_fix      = qneg_q ? -opa_q : opa_q;
  assign r_fix      = rneg_q ? -acc_q : acc_q;

  muldiv_divstep #(.XLEN(XLEN)) u_divstep (
    .rem_in  (acc_q),
    .quo_in  (opa_q),
    .div_in  (opb_q),
    .rem_out (ds_rem),
    .quo_out (ds_quo)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    word_d       = word_q;
    is_rem_d     = is_rem_q;
    qneg_d       = qneg_q;
    rneg_d       = rneg_q;
    out_valid_d  = out_valid_q;
    busy_d       = busy_q;
    out_result_d = out_result_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && !flush) begin
          word_d   = in_word;
          is_rem_d = is_rem;
          cnt_d    = in_word ? CNT_W'(31) : CNT_W'(XLEN-1);
          busy_d   = 1'b1;
          if (is_mul) begin
`ifdef MULDIV_FAST_MUL_EN
            out_result_d = fin(a_ext * b_ext, in_word);
            out_valid_d  = 1'b1;
            state_d      = ST_DONE;
`else
            acc_d   = '0;
            opa_d   = a_ext;
            opb_d   = b_ext;
            state_d = ST_MUL;
`endif
          end else if (div_zero) begin
            out_result_d = fin(is_rem ? a_ext : '1, in_word);
            out_valid_d  = 1'b1;
            state_d      = ST_DONE;
          end else if (ovf) begin
            out_result_d = fin(is_rem ? '0 : a_ext, in_word);
            out_valid_d  = 1'b1;
            state_d      = ST_DONE;
          end else begin
            // Word dividends are left-aligned so the first step sees bit 31.
            acc_d   = '0;
            opa_d   = in_word ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag;
            opb_d   = b_mag;
            qneg_d  = sa ^ sb;
            rneg_d  = sa;
            state_d = ST_DIV;
          end
        end
      end
      ST_MUL: begin
        acc_d = mul_acc_nx;
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
        if (cnt_q == '0) begin
          out_result_d = fin(mul_acc_nx, word_q);
          out_valid_d  = 1'b1;
          state_d      = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DIV: begin
        acc_d = ds_rem;
        opa_d = ds_quo;
        if (cnt_q == '0) state_d = ST_FIXUP;
        else cnt_d = cnt_q - 1'b1;
      end
      ST_FIXUP: begin
        out_result_d = fin(is_rem_q ? r_fix : q_fix, word_q);
        out_valid_d  = 1'b1;
        state_d      = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush beats any handshake or iteration in progress.
    if (flush && state_q != ST_IDLE) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      word_q       <= 1'b0;
      is_rem_q     <= 1'b0;
      qneg_q       <= 1'b0;
      rneg_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      out_result_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      word_q       <= word_d;
      is_rem_q     <= is_rem_d;
      qneg_q       <= qneg_d;
      rneg_q       <= rneg_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      out_result_q <= out_result_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - directed self-checking bench for muldiv_seq
// Honours MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_muldiv_seq;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL64_LAT = 1;
  localparam int MULW_LAT  = 1;
`else
  localparam int MUL64_LAT = 65;
  localparam int MULW_LAT  = 33;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = 3'd0;
  logic        in_word = 1'b0;
  logic [63:0] in_a = '0;
  logic [63:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_result;
  logic        busy;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.XLEN(64), .CNT_W(7)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_word    (in_word),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_word = w; in_a = a; in_b = b;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_busy_t1"}, 64'(busy), 64'd1);
    wait_valid(lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, out_result, exp);
    check({tag, "_busy_v"}, 64'(busy), 64'd1);
    @(negedge clk);
    check({tag, "_vdrop"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int lat;
    logic seen_valid;

    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_result", out_result, 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    run_op("mul_7_m3", 3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, MUL64_LAT);
    run_op("divw_m7_2", 3'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34);
    run_op("remw_m7_2", 3'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34);
    run_op("divu_by0", 3'd2, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("rem_ovf", 3'd3, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
    run_op("divuw_sext", 3'd2, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 34);
    run_op("div_100_m7", 3'd1, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 66);
    run_op("rem_100_m7", 3'd3, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 66);
    run_op("mulw_sext", 3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, MULW_LAT);
    run_op("rsvd_as_mul", 3'd6, 1'b0, 64'd6, 64'd9, 64'd54, MUL64_LAT);

    // Result held while consumer stalls; next op waits for the handshake.
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd2; in_word = 1'b0; in_a = 64'd100; in_b = 64'd7;
    @(negedge clk);
    in_op = 3'd0; in_a = 64'd3; in_b = 64'd4;
    wait_valid(lat);
    check("stall_lat", 64'(lat), 64'd66);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_result", out_result, 64'd14);
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("hs_vdrop", 64'(out_valid), 64'd0);
    check("hs_busy", 64'(busy), 64'd0);
    check("hs_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("next_accept_busy", 64'(busy), 64'd1);
    wait_valid(lat);
    check("next_mul_lat", 64'(lat), 64'(MUL64_LAT));
    check("next_mul_res", out_result, 64'd12);
    @(negedge clk);

    // Flush during divide.
    in_valid = 1'b1; in_op = 3'd1; in_word = 1'b0; in_a = 64'd1000; in_b = 64'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    seen_valid = out_valid;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    check("flush_no_valid", 64'(seen_valid), 64'd0);
    in_valid = 1'b1; flush = 1'b1; in_op = 3'd0; in_a = 64'd5; in_b = 64'd5;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_reject", 64'(busy), 64'd0);
    run_op("mul_3_4", 3'd0, 1'b0, 64'd3, 64'd4, 64'd12, MUL64_LAT);

    // Asynchronous reset mid-divide.
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd1; in_a = 64'd77; in_b = 64'd5;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_result", out_result, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("arst_in_ready", 64'(in_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
